// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

    // rr_pick works on vectors padded to this many requesters.
    localparam int RR_MAX  = 8;
    localparam int RR_IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Returns the first set bit of req at or after last+1, wrapping modulo n.
    // Returns 0 when req is empty; callers qualify with |req.
    function automatic logic [RR_IDXW-1:0] rr_pick(
        input logic [RR_MAX-1:0]  req,
        input logic [RR_IDXW-1:0] last,
        input int unsigned        n
    );
        logic [RR_IDXW-1:0] pick;
        logic               hit;
        int unsigned        idx;
        pick = '0;
        hit  = 1'b0;
        for (int unsigned off = 1; off <= RR_MAX; off++) begin
            if (off <= n) begin
                idx = (int'(last) + off) % n;
                if (!hit && req[idx[RR_IDXW-1:0]]) begin
                    hit  = 1'b1;
                    pick = idx[RR_IDXW-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick_comb.sv
// Combinational rotate-priority encoder: one-hot grant for the first request after last_i.
module rr_pick_comb
    import fifo_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic          found_o
);

    logic [RR_MAX-1:0]  req_pad;
    logic [RR_IDXW-1:0] last_pad;
    logic [RR_IDXW-1:0] pick;

    always_comb begin
        req_pad           = '0;
        req_pad[N-1:0]    = req_i;
        last_pad          = '0;
        last_pad[LW-1:0]  = last_i;
    end

    assign pick    = rr_pick(req_pad, last_pad, N);
    assign found_o = |req_i;
    assign gnt_o   = found_o ? (N'(1) << pick) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ valid/ready producers.
// Handshake: a beat transfers on a cycle where req_valid[i] && req_ready[i]; that is exactly fifo_wr.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    output logic [N_REQ-1:0]    grant,
    output logic                busy
);

    localparam int LG_W = $clog2(N_REQ);
    localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LG_W-1:0]   last_grant_q, last_grant_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic              pick_found;
    logic [LG_W-1:0]   g_idx;
    logic              g_valid;
    logic [DW-1:0]     g_data;
    logic              in_grant;
    logic              accept;
    logic              burst_last;

    rr_pick_comb #(
        .N  (N_REQ),
        .LW (LG_W)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_grant_q),
        .gnt_o   (pick_gnt),
        .found_o (pick_found)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx = LG_W'(i);
            end
        end
    end

    assign g_valid    = req_valid[g_idx];
    assign g_data     = req_data[g_idx*DW +: DW];
    assign in_grant   = (state_q == GRANT) && (|grant_q);
    assign accept     = in_grant && g_valid && !fifo_full;
    assign burst_last = (beat_cnt_q == BC_W'(MAX_BURST - 1));

    // Ready only depends on grant and full so a producer never sees ready wiggle with its own valid.
    assign req_ready = (in_grant && !fifo_full) ? grant_q : '0;
    assign fifo_wr   = accept;
    assign fifo_din  = in_grant ? g_data : '0;
    assign grant     = grant_q;
    assign busy      = (state_q == GRANT);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_gnt;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A paused producer releases at once; a full FIFO freezes everything.
                if (!g_valid || (accept && burst_last)) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_grant_d = g_idx;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            last_grant_q <= LG_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: handshake producers, a behavioural 16-entry FIFO, per-scenario checks.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wr;
    logic [W-1:0]   fifo_din;
    logic [N-1:0]   grant;
    logic           busy;

    logic           full_force;
    logic           use_model;
    int             mdl_cnt;
    int             overflow;
    logic [W-1:0]   mdl_q[$];
    logic [W-1:0]   exp_q[$];

    logic [W-1:0]   src_mem [N][16];
    int             src_head [N];
    int             src_len [N];
    logic [N-1:0]   en;

    int             asserts;
    int             failures;

    always #5 clk = ~clk;

    assign fifo_full = use_model ? (mdl_cnt == 16) : full_force;

    fifo_wr_arbiter #(.N_REQ(N), .DW(W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && (src_head[i] < src_len[i])) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = src_mem[i][src_head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = '0;
            end
        end
    endtask

    task automatic load(input int i, input logic [W-1:0] base, input int n);
        for (int j = 0; j < n; j++) src_mem[i][j] = base + W'(j);
        src_head[i] = 0;
        src_len[i]  = n;
    endtask

    // One clock: capture the handshake before the edge, update producers/FIFO model after it.
    task automatic step();
        logic [N-1:0] fire;
        logic         wr_s;
        logic [W-1:0] din_s;
        fire  = req_valid & req_ready;
        wr_s  = fifo_wr;
        din_s = fifo_din;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fire[i]) src_head[i]++;
        if (use_model && wr_s) begin
            if (mdl_cnt >= 16) overflow++;
            else begin
                mdl_q.push_back(din_s);
                mdl_cnt++;
            end
        end
        drive();
        #1;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        en         = '0;
        full_force = 1'b0;
        use_model  = 1'b0;
        mdl_q.delete();
        exp_q.delete();
        mdl_cnt    = 0;
        overflow   = 0;
        for (int i = 0; i < N; i++) load(i, 8'h00, 0);
        drive();
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) load(i, 8'h50 + W'(i * 16), 4);
        en = 4'b1111;
        drive();
        @(posedge clk);
        #1;
        asserts++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got %b exp 0000", grant); end
        asserts++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        asserts++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got %b exp 0", fifo_wr); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        asserts++; if (fifo_din !== 8'h00) begin failures++; $display("FAIL reset_din got %h exp 00", fifo_din); end
        rst = 1'b0;
        #1;
        asserts++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_idle_grant got %b exp 0000", grant); end
        step();
        asserts++; if (grant !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got %b exp 0001", grant); end
        asserts++; if (fifo_wr !== 1'b1 || fifo_din !== 8'h50) begin
            failures++; $display("FAIL reset_first_write got wr=%b din=%h exp wr=1 din=50", fifo_wr, fifo_din);
        end
    endtask

    task automatic test_single();
        logic [3:0] eg [10];
        logic       ew [10];
        logic [7:0] ed [10];
        eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ed = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'h00, 8'h00};
        reset_dut();
        load(2, 8'hA0, 6);
        en = 4'b0100;
        drive();
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            asserts++; if (grant !== eg[k]) begin failures++; $display("FAIL single_grant k=%0d got %b exp %b", k, grant, eg[k]); end
            asserts++; if (fifo_wr !== ew[k]) begin failures++; $display("FAIL single_wr k=%0d got %b exp %b", k, fifo_wr, ew[k]); end
            if (ew[k]) begin
                asserts++; if (fifo_din !== ed[k]) begin failures++; $display("FAIL single_din k=%0d got %h exp %h", k, fifo_din, ed[k]); end
            end
        end
    endtask

    task automatic test_all_four();
        int         r, b, q;
        logic [3:0] eg;
        logic [7:0] ed;
        reset_dut();
        for (int i = 0; i < N; i++) load(i, W'(i * 16), 8);
        en = 4'b1111;
        drive();
        #1;
        asserts++; if (grant !== 4'b0000) begin failures++; $display("FAIL rr_start_grant got %b exp 0000", grant); end
        for (int k = 1; k <= 25; k++) begin
            step();
            r = (k - 1) / 5;
            b = (k - 1) % 5;
            if (b == 4) begin
                eg = 4'b0000;
                ed = 8'h00;
            end else begin
                q  = r % 4;
                eg = 4'(1 << q);
                ed = 8'(q * 16 + (r / 4) * 4 + b);
            end
            asserts++; if (grant !== eg) begin failures++; $display("FAIL rr_grant k=%0d got %b exp %b", k, grant, eg); end
            asserts++; if (req_ready !== eg) begin failures++; $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, eg); end
            asserts++; if (fifo_wr !== (b != 4)) begin failures++; $display("FAIL rr_wr k=%0d got %b exp %b", k, fifo_wr, b != 4); end
            if (b != 4) begin
                asserts++; if (fifo_din !== ed) begin failures++; $display("FAIL rr_din k=%0d got %h exp %h", k, fifo_din, ed); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] eg [9];
        logic       ew [9];
        logic [7:0] ed [9];
        eg = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ed = '{8'h00, 8'hB0, 8'hB1, 8'h00, 8'h00, 8'h00, 8'hB2, 8'hB3, 8'h00};
        reset_dut();
        load(1, 8'hB0, 8);
        en = 4'b0010;
        drive();
        #1;
        for (int k = 1; k <= 8; k++) begin
            step();
            full_force = (k >= 3 && k <= 5);
            #1;
            asserts++; if (grant !== eg[k]) begin failures++; $display("FAIL bp_grant k=%0d got %b exp %b", k, grant, eg[k]); end
            asserts++; if (fifo_wr !== ew[k]) begin failures++; $display("FAIL bp_wr k=%0d got %b exp %b", k, fifo_wr, ew[k]); end
            asserts++; if (req_ready !== (ew[k] ? 4'b0010 : 4'b0000)) begin
                failures++; $display("FAIL bp_ready k=%0d got %b exp %b", k, req_ready, ew[k] ? 4'b0010 : 4'b0000);
            end
            if (ew[k]) begin
                asserts++; if (fifo_din !== ed[k]) begin failures++; $display("FAIL bp_din k=%0d got %h exp %h", k, fifo_din, ed[k]); end
            end
        end
    endtask

    task automatic test_valid_drop();
        logic [3:0] eg [7];
        logic       ew [7];
        logic [7:0] ed [7];
        eg = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
        ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ed = '{8'h00, 8'hC0, 8'hC1, 8'h00, 8'h00, 8'hD0, 8'hD1};
        reset_dut();
        load(3, 8'hC0, 2);
        load(0, 8'hD0, 4);
        en = 4'b1000;
        drive();
        #1;
        for (int k = 1; k <= 6; k++) begin
            step();
            asserts++; if (grant !== eg[k]) begin failures++; $display("FAIL drop_grant k=%0d got %b exp %b", k, grant, eg[k]); end
            asserts++; if (fifo_wr !== ew[k]) begin failures++; $display("FAIL drop_wr k=%0d got %b exp %b", k, fifo_wr, ew[k]); end
            if (ew[k]) begin
                asserts++; if (fifo_din !== ed[k]) begin failures++; $display("FAIL drop_din k=%0d got %h exp %h", k, fifo_din, ed[k]); end
            end
            if (k == 1) begin
                en = 4'b1001;
                drive();
                #1;
            end
            if (k >= 2 && k <= 3) begin
                asserts++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL drop_ready0 k=%0d got %b exp 0", k, req_ready[0]); end
            end
            if (k == 4) begin
                asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy k=%0d got %b exp 0", k, busy); end
            end
        end
    endtask

    task automatic test_fifo_integration();
        logic [W-1:0] got;
        logic [W-1:0] want;
        reset_dut();
        use_model = 1'b1;
        for (int i = 0; i < N; i++) load(i, W'(i * 16), 5);
        for (int r = 0; r < 4; r++) for (int b = 0; b < 4; b++) exp_q.push_back(W'(r * 16 + b));
        en = 4'b1111;
        drive();
        #1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k >= 20) begin
                asserts++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL fifo_stall_wr k=%0d got %b exp 0", k, fifo_wr); end
            end
            if (k >= 21) begin
                asserts++; if (grant !== 4'b0001 || req_ready !== 4'b0000) begin
                    failures++; $display("FAIL fifo_stall_hold k=%0d got grant=%b ready=%b exp 0001/0000", k, grant, req_ready);
                end
            end
        end
        asserts++; if (mdl_cnt !== 16) begin failures++; $display("FAIL fifo_count got %0d exp 16", mdl_cnt); end
        asserts++; if (overflow !== 0) begin failures++; $display("FAIL fifo_overflow got %0d exp 0", overflow); end
        asserts++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL fifo_full got %b exp 1", fifo_full); end
        for (int j = 0; j < 16; j++) begin
            got  = (mdl_q.size() != 0) ? mdl_q.pop_front() : 8'hxx;
            want = exp_q.pop_front();
            asserts++; if (got !== want) begin failures++; $display("FAIL fifo_order j=%0d got %h exp %h", j, got, want); end
        end
        mdl_q.delete();
        mdl_cnt = 0;
        #1;
        for (int r = 0; r < 4; r++) exp_q.push_back(W'(r * 16 + 4));
        for (int k = 0; k < 20; k++) step();
        asserts++; if (mdl_cnt !== 4) begin failures++; $display("FAIL fifo_tail_count got %0d exp 4", mdl_cnt); end
        for (int j = 0; j < 4; j++) begin
            got  = (mdl_q.size() != 0) ? mdl_q.pop_front() : 8'hxx;
            want = exp_q.pop_front();
            asserts++; if (got !== want) begin failures++; $display("FAIL fifo_tail j=%0d got %h exp %h", j, got, want); end
        end
        use_model = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        load(1, 8'hE0, 8);
        load(0, 8'hF0, 4);
        en = 4'b0010;
        drive();
        #1;
        step();
        asserts++; if (grant !== 4'b0010 || fifo_din !== 8'hE0) begin
            failures++; $display("FAIL rmb_first got grant=%b din=%h exp 0010/E0", grant, fifo_din);
        end
        step();
        asserts++; if (fifo_wr !== 1'b1 || fifo_din !== 8'hE1) begin
            failures++; $display("FAIL rmb_second got wr=%b din=%h exp 1/E1", fifo_wr, fifo_din);
        end
        rst = 1'b1;
        en  = 4'b0011;
        drive();
        #1;
        step();
        asserts++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL rmb_wr got %b exp 0", fifo_wr); end
        asserts++; if (grant !== 4'b0000 || req_ready !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL rmb_cleared got grant=%b ready=%b busy=%b exp 0000/0000/0", grant, req_ready, busy);
        end
        rst = 1'b0;
        #1;
        step();
        asserts++; if (grant !== 4'b0001) begin failures++; $display("FAIL rmb_regrant got %b exp 0001", grant); end
        asserts++; if (fifo_wr !== 1'b1 || fifo_din !== 8'hF0) begin
            failures++; $display("FAIL rmb_regrant_write got wr=%b din=%h exp 1/F0", fifo_wr, fifo_din);
        end
    endtask

    initial begin
        asserts    = 0;
        failures   = 0;
        rst        = 1'b1;
        en         = '0;
        full_force = 1'b0;
        use_model  = 1'b0;
        mdl_cnt    = 0;
        overflow   = 0;
        req_valid  = '0;
        req_data   = '0;
        for (int i = 0; i < N; i++) load(i, 8'h00, 0);

        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_valid_drop();
        test_fifo_integration();
        test_reset_mid_burst();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 16-deep, 8-bit synchronous FIFO between N_REQ producers.
- Each producer has a valid/ready handshake. The arbiter drives the FIFO write port (fifo_wr, fifo_din) and observes fifo_full.
- Each grant is held for a bounded burst so that no producer starves. The FIFO read side is not touched by this block.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 8, data width; must match the FIFO din width
- MAX_BURST, 4, maximum accepted beats per grant (1..16)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  N_REQ  per-requester data valid
- req_data  input  N_REQ*DW  requester i data in bits [i*DW +: DW]
- req_ready  output  N_REQ  per-requester accept; at most one bit high
- fifo_full  input  1  FIFO full flag
- fifo_wr  output  1  FIFO write strobe
- fifo_din  output  DW  FIFO write data
- grant  output  N_REQ  registered one-hot current grant; 0 when idle
- busy  output  1  high while in state GRANT

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant=0, beat_cnt=0, last_grant=N_REQ-1, so requester 0 has top priority after reset.
  - Combinational outputs then give req_ready=0, fifo_wr=0, busy=0. fifo_din is don't-care but is driven 0 when grant=0.
  - Reset mid-burst aborts the burst immediately. No write occurs in the reset cycle, because fifo_wr is gated by grant, which is 0 after reset.
- State IDLE:
  - If any req_valid is set, grant is loaded with the first requester with valid high, searching cyclically from last_grant+1.
  - beat_cnt is cleared and state moves to GRANT.
  - No transfer happens in IDLE, so latency from first valid to first FIFO write is 1 cycle minimum.
- State GRANT, with g = granted index:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr = req_valid[g] && !fifo_full.
  - fifo_din = req_data[g].
  - An accept (fifo_wr=1) increments beat_cnt.
- Release from GRANT (next state IDLE, last_grant<=g, grant<=0) happens on either:
  - an accept while beat_cnt==MAX_BURST-1, i.e. the burst limit is reached; or
  - req_valid[g]==0 in a GRANT cycle, i.e. the producer has paused.
- Release always costs one IDLE bubble cycle before the next grant.
- Full backpressure:
  - While fifo_full=1 and req_valid[g]=1, the grant is held, ready stays 0, beat_cnt is frozen and there is no release.
  - Data must stay stable at the producer, per standard valid/ready rules.
- Producer rules:
  - Valid must not drop without a transfer. A drop is tolerated anyway and simply releases the grant.
  - Non-granted requesters wait with no timeout.
- Fairness: with all N_REQ requesters continuously valid and the FIFO never full, each receives MAX_BURST beats per round in order 0,1,...,N_REQ-1. Worst-case wait is (N_REQ-1)*(MAX_BURST+1) cycles.
- Counter widths:
  - beat_cnt width is clog2(MAX_BURST), minimum 1 bit, and it never wraps.
  - last_grant is an index of clog2(N_REQ) bits. Its cyclic search wraps from N_REQ-1 to 0.
- FIFO coupling:
  - The FIFO gives a write priority over a read in the same cycle, so a concurrent read is ignored there.
  - This is accepted system behaviour; the arbiter does not suppress writes to protect reads.
  - fifo_full is sampled combinationally, so the write never targets a full FIFO.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - the default constants N_REQ_DEF=4, DW_DEF=8, MAX_BURST_DEF=4;
  - an rr_pick function (request vector, last index -> next index).
- One sub-module, rr_pick_comb: a purely combinational rotate-priority encoder taking req and last_grant and producing a one-hot grant plus a found flag. It is reusable by other arbiters.

Test Plan:
- Reset then single requester: req_valid=4'b0100, data 0xA0..0xA5 held by handshake.
  - Expected: grant=4'b0100 one cycle after valid.
  - Writes 0xA0..0xA3 on consecutive cycles, then one IDLE bubble, then re-grant to 2 for 0xA4, 0xA5.
- All four requesters continuously valid, FIFO drained every cycle.
  - Expected grant order 0,1,2,3,0; 4 beats each; exactly one idle cycle between grants; fifo_din matches the granted source.
- Backpressure: force fifo_full=1 for 3 cycles mid-burst after 2 beats of requester 1.
  - Expected: grant held, req_ready=0, fifo_wr=0 for those 3 cycles.
  - Exactly 2 more beats follow after full drops, then release.
- Valid drop: requester 3 asserts for 2 beats then deasserts while requester 0 is valid.
  - Expected: release on the drop cycle; next grant goes to 0 (wrap-around from last_grant=3).
- Real FIFO integration: 4 requesters each push 5 unique bytes into the 16-entry FIFO with no reads.
  - Expected: full asserts after 16 writes, the arbiter stalls with no overflow, and count stays 16.
  - Then read all: the order matches the scoreboard.
- Reset mid-burst: assert rst for 1 cycle during requester 1's second beat.
  - Expected: no fifo_wr in the reset cycle; grant=0 after it; the next arbitration starts from requester 0.
